// File: rtl/regarb_pkg.sv
// Shared types, widths and ID helpers for the register-file port arbiter.
// The optional starvation guard is enabled by defining REGARB_STARVE_EN.
package regarb_pkg;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 6;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   data_t;

    localparam reg_id_t REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_E    = 2'd1,
        GNT_M    = 2'd2
    } wr_gnt_e;

    function automatic logic is_valid_id(input reg_id_t id);
        return id < REG_ID_W'(NUM_REGS);
    endfunction

    // A pending write only blocks a read when it targets a real register.
    function automatic logic id_hit(input reg_id_t src, input logic wr_valid, input reg_id_t wr_dst);
        return wr_valid && is_valid_id(wr_dst) && (src == wr_dst);
    endfunction

endpackage

// File: rtl/regarb_starve_ctr.sv
// Saturating E-stall counter; raises a one-cycle force flag after STARVE_MAX
// consecutive stalls so E is granted ahead of M. Used only with REGARB_STARVE_EN.
module regarb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic e_valid_i,
    input  logic e_ready_i,
    output logic force_e_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_q, force_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            force_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!e_valid_i || e_ready_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Flag drops as soon as E transfers, so it never outlives one grant.
        force_d = e_valid_i && !e_ready_i && (cnt_q == CNT_MAX);
    end

    assign force_e_o = force_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port between E and M writers and issues
// hazard-checked operand reads. Define REGARB_STARVE_EN for the E starvation guard.
module regfile_port_arbiter
    import regarb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_dst,
    input  logic [31:0] e_val,
    output logic        e_ready,
    input  logic        m_valid,
    input  logic [3:0]  m_dst,
    input  logic [31:0] m_val,
    output logic        m_ready,
    input  logic        rd_valid,
    input  logic [3:0]  rd_srcA,
    input  logic [3:0]  rd_srcB,
    output logic        rd_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_valA,
    output logic [31:0] rsp_valB,
    input  logic [31:0] rf_valA,
    input  logic [31:0] rf_valB,
    output logic [3:0]  dstM,
    output logic [31:0] valM,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic        err_bad_id
);

    // Handshake: a transfer happens in any cycle where valid && ready; the
    // requester holds valid and payload stable until then. Readies are
    // combinational from this cycle's requests and are forced low in reset.

    wr_gnt_e gnt;
    logic    force_e;
    logic    hazard;
    logic    rd_xfer;
    logic    bad_id_seen;

    logic    rsp_valid_q, rsp_valid_d;
    logic    err_q, err_d;

`ifdef REGARB_STARVE_EN
    regarb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clock    (clock),
        .reset    (reset),
        .e_valid_i(e_valid),
        .e_ready_i(e_ready),
        .force_e_o(force_e)
    );
`else
    logic [31:0] unused_starve_max;
    assign unused_starve_max = 32'(STARVE_MAX);
    assign force_e = 1'b0;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (force_e && e_valid) begin
                gnt = GNT_E;
            end else if (m_valid) begin
                gnt = GNT_M;
            end else if (e_valid) begin
                gnt = GNT_E;
            end
        end
    end

    always_comb begin
        hazard = id_hit(rd_srcA, e_valid, e_dst) || id_hit(rd_srcB, e_valid, e_dst) ||
                 id_hit(rd_srcA, m_valid, m_dst) || id_hit(rd_srcB, m_valid, m_dst);
        rd_xfer = !reset && rd_valid && !hazard;
    end

    always_comb begin
        e_ready  = (gnt == GNT_E);
        m_ready  = (gnt == GNT_M);
        rd_ready = rd_xfer;
        dstM     = REG_NONE;
        valM     = '0;
        case (gnt)
            GNT_E: begin
                dstM = e_dst;
                valM = e_val;
            end
            GNT_M: begin
                dstM = m_dst;
                valM = m_val;
            end
            default: ;
        endcase
        rA = rd_xfer ? rd_srcA : REG_NONE;
        rB = rd_xfer ? rd_srcB : REG_NONE;
    end

    always_comb begin
        bad_id_seen = ((gnt == GNT_E) && !is_valid_id(e_dst)) ||
                      ((gnt == GNT_M) && !is_valid_id(m_dst)) ||
                      (rd_xfer && (!is_valid_id(rd_srcA) || !is_valid_id(rd_srcB)));
        err_d       = err_q || bad_id_seen;
        rsp_valid_d = rd_xfer;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    // The register file holds its read outputs, so data is passed straight through.
    assign rsp_valid  = rsp_valid_q;
    assign rsp_valA   = rf_valA;
    assign rsp_valB   = rf_valB;
    assign err_bad_id = err_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural six-entry register file.
module tb_regfile_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        e_valid, m_valid, rd_valid;
  logic [3:0]  e_dst, m_dst, rd_srcA, rd_srcB;
  logic [31:0] e_val, m_val;
  logic        e_ready, m_ready, rd_ready, rsp_valid, err_bad_id;
  logic [31:0] rsp_valA, rsp_valB, rf_valA, rf_valB, valM;
  logic [3:0]  dstM, rA, rB;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [0:5];
  logic [31:0] exp_rf [0:5];

  regfile_port_arbiter dut (
    .clock(clock), .reset(reset),
    .e_valid(e_valid), .e_dst(e_dst), .e_val(e_val), .e_ready(e_ready),
    .m_valid(m_valid), .m_dst(m_dst), .m_val(m_val), .m_ready(m_ready),
    .rd_valid(rd_valid), .rd_srcA(rd_srcA), .rd_srcB(rd_srcB), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_valA(rsp_valA), .rsp_valB(rsp_valB),
    .rf_valA(rf_valA), .rf_valB(rf_valB),
    .dstM(dstM), .valM(valM), .rA(rA), .rB(rB),
    .err_bad_id(err_bad_id)
  );

  always #5 clock = ~clock;

  // Register file: cleared in reset, write port dstM/valM, registered reads that hold on 4'hF.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) rf[i] <= 32'h0;
      rf_valA <= 32'h0;
      rf_valB <= 32'h0;
    end else begin
      if (dstM < 4'd6) rf[dstM] <= valM;
      if (rA != 4'hF) rf_valA <= (rA < 4'd6) ? rf[rA] : 32'h0;
      if (rB != 4'hF) rf_valB <= (rB < 4'd6) ? rf[rB] : 32'h0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    e_valid = 0; e_dst = 0; e_val = 0;
    m_valid = 0; m_dst = 0; m_val = 0;
    rd_valid = 0; rd_srcA = 0; rd_srcB = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    e_valid = 1; e_dst = 4'd1; e_val = 32'h1;
    m_valid = 1; m_dst = 4'd2; m_val = 32'h2;
    rd_valid = 1; rd_srcA = 4'd3; rd_srcB = 4'd4;
    tick();
    tick();
    n_checks++; if (e_ready !== 1'b0) begin n_fail++; $display("FAIL reset_e_ready: got %b want 0", e_ready); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_ready: got %b want 0", m_ready); end
    n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
    n_checks++; if (dstM !== 4'hF) begin n_fail++; $display("FAIL reset_dstM: got %h want f", dstM); end
    n_checks++; if (valM !== 32'h0) begin n_fail++; $display("FAIL reset_valM: got %h want 0", valM); end
    n_checks++; if ({rA, rB} !== 8'hFF) begin n_fail++; $display("FAIL reset_rArB: got %h%h want ff", rA, rB); end
    reset = 0;
    idle_inputs();
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (err_bad_id !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_bad_id); end
  endtask

  task automatic test_write_collision();
    m_valid = 1; m_dst = 4'd2; m_val = 32'h11;
    e_valid = 1; e_dst = 4'd3; e_val = 32'h22;
    #1;
    n_checks++; if ({m_ready, e_ready} !== 2'b10) begin n_fail++; $display("FAIL coll_t0_grant: got m=%b e=%b want m=1 e=0", m_ready, e_ready); end
    n_checks++; if (dstM !== 4'd2 || valM !== 32'h11) begin n_fail++; $display("FAIL coll_t0_port: got %h/%h want 2/11", dstM, valM); end
    tick();
    m_valid = 0;
    #1;
    n_checks++; if ({m_ready, e_ready} !== 2'b01) begin n_fail++; $display("FAIL coll_t1_grant: got m=%b e=%b want m=0 e=1", m_ready, e_ready); end
    n_checks++; if (dstM !== 4'd3 || valM !== 32'h22) begin n_fail++; $display("FAIL coll_t1_port: got %h/%h want 3/22", dstM, valM); end
    tick();
    e_valid = 0;
    rd_valid = 1; rd_srcA = 4'd2; rd_srcB = 4'd3;
    #1;
    n_checks++; if (rd_ready !== 1'b1 || rA !== 4'd2 || rB !== 4'd3) begin n_fail++; $display("FAIL coll_rd_accept: got rdy=%b rA=%h rB=%h want 1/2/3", rd_ready, rA, rB); end
    tick();
    rd_valid = 0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL coll_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_valA !== 32'h11 || rsp_valB !== 32'h22) begin n_fail++; $display("FAIL coll_rsp_data: got %h/%h want 11/22", rsp_valA, rsp_valB); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL coll_rsp_clear: got %b want 0", rsp_valid); end
  endtask

  task automatic test_raw_hazard();
    m_valid = 1; m_dst = 4'd4; m_val = 32'hA5A5_0004;
    e_valid = 1; e_dst = 4'd1; e_val = 32'h0000_0101;
    rd_valid = 1; rd_srcA = 4'd4; rd_srcB = 4'd1;
    #1;
    n_checks++; if ({m_ready, e_ready, rd_ready} !== 3'b100) begin n_fail++; $display("FAIL raw_t0: got m=%b e=%b rd=%b want 1/0/0", m_ready, e_ready, rd_ready); end
    n_checks++; if ({rA, rB} !== 8'hFF) begin n_fail++; $display("FAIL raw_t0_sel: got %h%h want ff", rA, rB); end
    tick();
    m_valid = 0;
    #1;
    n_checks++; if ({e_ready, rd_ready} !== 2'b10) begin n_fail++; $display("FAIL raw_t1: got e=%b rd=%b want 1/0", e_ready, rd_ready); end
    tick();
    e_valid = 0;
    #1;
    n_checks++; if (rd_ready !== 1'b1 || rA !== 4'd4 || rB !== 4'd1) begin n_fail++; $display("FAIL raw_t2_accept: got rdy=%b rA=%h rB=%h want 1/4/1", rd_ready, rA, rB); end
    tick();
    rd_valid = 0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL raw_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_valA !== 32'hA5A5_0004 || rsp_valB !== 32'h0000_0101) begin n_fail++; $display("FAIL raw_rsp_data: got %h/%h want a5a50004/00000101", rsp_valA, rsp_valB); end
    tick();
  endtask

  task automatic test_bad_id();
    m_valid = 1; m_dst = 4'd7; m_val = 32'hDEAD_BEEF;
    rd_valid = 1; rd_srcA = 4'd2; rd_srcB = 4'd3;
    #1;
    n_checks++; if (m_ready !== 1'b1 || dstM !== 4'd7) begin n_fail++; $display("FAIL bad_accept: got rdy=%b dstM=%h want 1/7", m_ready, dstM); end
    n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL bad_rd_parallel: got %b want 1", rd_ready); end
    n_checks++; if (err_bad_id !== 1'b0) begin n_fail++; $display("FAIL bad_err_early: got %b want 0", err_bad_id); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (err_bad_id !== 1'b1) begin n_fail++; $display("FAIL bad_err_set: got %b want 1", err_bad_id); end
    n_checks++; if (rsp_valA !== 32'h11 || rsp_valB !== 32'h22) begin n_fail++; $display("FAIL bad_rsp_data: got %h/%h want 11/22", rsp_valA, rsp_valB); end
    tick();
    n_checks++; if (err_bad_id !== 1'b1) begin n_fail++; $display("FAIL bad_err_sticky: got %b want 1", err_bad_id); end
  endtask

  task automatic test_starve();
    logic exp_e;
    m_valid = 1; m_dst = 4'd0; m_val = 32'h0000_00A0;
    e_valid = 1; e_dst = 4'd5; e_val = 32'h0000_0055;
    for (int c = 1; c <= 8; c++) begin
      #1;
`ifdef REGARB_STARVE_EN
      exp_e = (c == 6);
`else
      exp_e = 1'b0;
`endif
      n_checks++; if ({e_ready, m_ready} !== {exp_e, !exp_e}) begin n_fail++; $display("FAIL starve_c%0d: got e=%b m=%b want e=%b m=%b", c, e_ready, m_ready, exp_e, !exp_e); end
      tick();
      if (c == 6) begin
`ifdef REGARB_STARVE_EN
        e_valid = 0;
`endif
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    exp_rf[0] = 32'h0000_00A0;
    exp_rf[1] = 32'h0000_0101;
    exp_rf[2] = 32'h0000_0011;
    exp_rf[3] = 32'h0000_0022;
    exp_rf[4] = 32'hA5A5_0004;
`ifdef REGARB_STARVE_EN
    exp_rf[5] = 32'h0000_0055;
`else
    exp_rf[5] = 32'h0000_0000;
`endif
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        rd_valid = 1; rd_srcA = 4'(k); rd_srcB = 4'(5 - k);
      end else begin
        rd_valid = 0;
      end
      #1;
      if (k < 6) begin
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", k, rd_ready); end
      end
      if (k > 0) begin
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp_valid_%0d: got %b want 1", k - 1, rsp_valid); end
        n_checks++; if (rsp_valA !== exp_rf[k-1] || rsp_valB !== exp_rf[6-k]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h/%h want %h/%h", k - 1, rsp_valA, rsp_valB, exp_rf[k-1], exp_rf[6-k]); end
      end
      tick();
    end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp_end: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rd_valid = 1; rd_srcA = 4'd1; rd_srcB = 4'd2;
    #1;
    n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_rd_accept: got %b want 1", rd_ready); end
    tick();
    reset = 1;
    e_valid = 1; e_dst = 4'd1; e_val = 32'h7777_0001;
    m_valid = 1; m_dst = 4'd2; m_val = 32'h8888_0002;
    #1;
    n_checks++; if ({e_ready, m_ready, rd_ready} !== 3'b000) begin n_fail++; $display("FAIL rmid_readies: got e=%b m=%b rd=%b want 0/0/0", e_ready, m_ready, rd_ready); end
    n_checks++; if (dstM !== 4'hF) begin n_fail++; $display("FAIL rmid_dstM: got %h want f", dstM); end
    tick();
    reset = 0;
    idle_inputs();
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_dropped: got %b want 0", rsp_valid); end
    n_checks++; if (err_bad_id !== 1'b0) begin n_fail++; $display("FAIL rmid_err_cleared: got %b want 0", err_bad_id); end
    rd_valid = 1; rd_srcA = 4'd1; rd_srcB = 4'd2;
    #1;
    n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_post_accept: got %b want 1", rd_ready); end
    tick();
    rd_valid = 0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_valA !== 32'h0 || rsp_valB !== 32'h0) begin n_fail++; $display("FAIL rmid_post_data: got v=%b %h/%h want 1 0/0", rsp_valid, rsp_valA, rsp_valB); end
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_write_collision();
    test_raw_hazard();
    test_bad_id();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Arbitration and sequencing controller in front of the six-entry register file (r0–r5, 4-bit IDs, 32-bit data, one write port dstM/valM, registered read ports rA/valA and rB/valB). Shares the single write port between the execute-stage (E) and memory-stage (M) writers with valid/ready handshakes. Issues operand reads with read-after-write hazard stalling and returns a 1-cycle-latency response.

## Interface
- STARVE_MAX, 4: consecutive E-stall cycles before E is forced ahead of M (only with REGARB_STARVE_EN).
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- e_valid / e_dst / e_val  in  1/4/32  E write request.
- e_ready  out  1  E write accepted this cycle.
- m_valid / m_dst / m_val  in  1/4/32  M write request.
- m_ready  out  1  M write accepted this cycle.
- rd_valid / rd_srcA / rd_srcB  in  1/4/4  operand read request.
- rd_ready  out  1  read accepted this cycle.
- rsp_valid  out  1  read response valid.
- rsp_valA / rsp_valB  out  32/32  read data.
- rf_valA / rf_valB  in  32/32  register file read outputs.
- dstM / valM  out  4/32  register file write port.
- rA / rB  out  4/4  register file read selects.
- err_bad_id  out  1  sticky: a request with an ID ≥ 6 was accepted.

## Operation
- Write grant (combinational, per cycle): at most one of e_ready/m_ready high. Default priority M over E. Granted request drives dstM/valM. No grant drives dstM = 4'hF, valM = 0.
- Requesters hold valid/dst/val stable until ready. Transfer = valid && ready.
- Read hazard: rd_ready = rd_valid && no match of rd_srcA or rd_srcB against e_dst (when e_valid) or m_dst (when m_valid). Only IDs 0–5 are compared.
- Accepted read drives rA = rd_srcA, rB = rd_srcB. Otherwise rA = rB = 4'hF, and the register file holds valA/valB.
- rsp_valid is a register: set the cycle after a read transfer, cleared otherwise. rsp_valA/rsp_valB pass rf_valA/rf_valB through combinationally and are meaningful only when rsp_valid = 1.
- Read and write proceed in the same cycle when there is no hazard.
- IDs ≥ 6 are granted and accepted normally. The register file ignores them, and err_bad_id is set the cycle after acceptance.
- Reset: e_ready = m_ready = rd_ready = 0, dstM = rA = rB = 4'hF, valM = 0. rsp_valid, err_bad_id, starvation counter and force flag all clear to 0.
- Reset mid-operation: pending requests are dropped without transfer. An in-flight response is discarded (rsp_valid = 0 in the first post-reset cycle).

## Timing
- Write transferred in cycle t: register updated at the rising edge ending t.
- A read of that register is accepted no earlier than t+1, and its rsp_valid is high in t+2.
- Read latency: accepted in t, rsp_valid high in t+1.
- Back-to-back reads: one per cycle, and rsp_valid stays high continuously.
- Simultaneous E and M requests to the same ID: M is written at t and E at t+1 (or in reverse order when forced), so the second write wins.
- The register file is cleared in the reset cycle. The first accepted read after reset returns 0.

## Configuration
- REGARB_STARVE_EN defined:
  - Starvation counter increments each cycle that e_valid && !e_ready, saturating at STARVE_MAX.
  - When it equals STARVE_MAX, E takes priority over M on the next cycle.
  - The counter clears on an E transfer or when e_valid = 0.
- REGARB_STARVE_EN undefined: strict M-over-E priority. The counter logic and STARVE_MAX are unused, and E may starve indefinitely.

## Structure
- Package regarb_pkg: REG_ID_W = 4, DATA_W = 32, NUM_REGS = 6, REG_NONE = 4'hF, and an is_valid_id() function.
- One sub-module, regarb_starve_ctr: the saturating counter and force flag, instantiated only under REGARB_STARVE_EN.

## Test plan
- M write r2 = 0x11 and E write r3 = 0x22 in the same cycle -> M granted first, E one cycle later; a read of r2/r3 afterwards returns 0x11/0x22.
- Read r4 while m_valid with m_dst = 4 -> rd_ready = 0 until the M transfer; rsp_valid high two cycles after the write, with rsp_valA = written value.
- M held valid continuously plus E valid, with REGARB_STARVE_EN and STARVE_MAX = 4 -> E granted in the 6th cycle. Without the macro, E is never granted.
- Write to ID 7 -> accepted, dstM = 7, err_bad_id = 1 next cycle, r0–r5 unchanged.
- Reset asserted with a read in flight and both writers valid -> all readies 0, rsp_valid 0 in the cycle after reset, and a read after reset returns 0.
- Reads of r0–r5 back-to-back -> six consecutive rsp_valid cycles with correct data, no bubbles.
